// File: rtl/dbg_pkg.sv
// Shared types and control-bit positions for the debug access sequencer.
package dbg_pkg;

  typedef enum logic [2:0] {
    CMD_STATUS = 3'd0,
    CMD_HALT   = 3'd1,
    CMD_RESUME = 3'd2,
    CMD_STEP   = 3'd3,
    CMD_RD_GPR = 3'd4,
    CMD_WR_GPR = 3'd5,
    CMD_RD_CSR = 3'd6,
    CMD_WR_CSR = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_HALTED,
    ST_ACCESS,
    ST_STEP,
    ST_RESP
  } state_e;

  localparam int CTL_WE   = 0;
  localparam int CTL_RE   = 1;
  localparam int CTL_HALT = 2;
  localparam int CTL_CSR  = 3;

endpackage

// File: rtl/debug_access_ctrl.sv
// Debug access sequencer: halts/resumes/steps the core and sequences GPR/CSR
// accesses over the coprocessor IO port, one response per accepted command.
//
// state     | meaning
// ST_RUN    | core running, idle, ready for a command
// ST_HALTED | core held, idle, ready for a command
// ST_ACCESS | driving a GPR/CSR read (RD_SETTLE cycles) or write (1 cycle)
// ST_STEP   | control released for one cycle so one instruction retires
// ST_RESP   | response presented, waiting for rsp_ready
module debug_access_ctrl
  import dbg_pkg::*;
#(
  parameter int N         = 64,
  parameter int RD_SETTLE = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_cmd,
  input  logic [11:0]   req_addr,
  input  logic [N-1:0]  req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_err,
  output logic          halted,
  output logic [14:0]   coprocessorIOAddr,
  output logic [4:0]    coprocessorIOControl,
  output logic [N-1:0]  coprocessorIODataOut,
  input  logic [N-1:0]  coprocessorIODataIn
);

  localparam int CW = $clog2(RD_SETTLE + 1);

  state_e        state_q, state_d;
  logic          halt_q, halt_d;
  cmd_e          cmd_q, cmd_d;
  logic [11:0]   addr_q, addr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          is_csr, is_write, gpr_zero;

  assign is_csr   = (cmd_q == CMD_RD_CSR) || (cmd_q == CMD_WR_CSR);
  assign is_write = (cmd_q == CMD_WR_GPR) || (cmd_q == CMD_WR_CSR);
  assign gpr_zero = !is_csr && (addr_q[4:0] == 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
      cmd_q   <= CMD_STATUS;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    halt_d               = halt_q;
    cmd_d                = cmd_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    cnt_d                = cnt_q;
    rdata_d              = rdata_q;
    err_d                = err_q;
    req_ready            = (state_q == ST_RUN) || (state_q == ST_HALTED);
    coprocessorIOAddr    = '0;
    coprocessorIODataOut = '0;
    coprocessorIOControl = '0;
    // The step cycle drops the hold so exactly one instruction retires.
    coprocessorIOControl[CTL_HALT] = halt_q && (state_q != ST_STEP);

    case (state_q)
      ST_RUN, ST_HALTED: begin
        if (req_valid) begin
          cmd_d   = cmd_e'(req_cmd);
          addr_d  = req_addr;
          wdata_d = req_data;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
          case (cmd_e'(req_cmd))
            CMD_STATUS: rdata_d = {{(N-1){1'b0}}, halt_q};
            CMD_HALT:   halt_d = 1'b1;
            CMD_RESUME: halt_d = 1'b0;
            CMD_STEP: begin
              if (halt_q) state_d = ST_STEP;
              else        err_d   = 1'b1;
            end
            default: begin
              if (halt_q) begin
                state_d = ST_ACCESS;
                cnt_d   = CW'(RD_SETTLE - 1);
              end else begin
                err_d = 1'b1;
              end
            end
          endcase
        end
      end
      ST_ACCESS: begin
        coprocessorIOControl[CTL_CSR] = is_csr;
        coprocessorIOAddr = is_csr ? {3'b000, addr_q} : {10'b0, addr_q[4:0]};
        if (is_write) begin
          coprocessorIOControl[CTL_WE] = 1'b1;
          coprocessorIODataOut         = wdata_q;
          state_d                      = ST_RESP;
        end else begin
          coprocessorIOControl[CTL_RE] = 1'b1;
          if (cnt_q == '0) begin
            rdata_d = gpr_zero ? '0 : coprocessorIODataIn;
            state_d = ST_RESP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      ST_STEP: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = halt_q ? ST_HALTED : ST_RUN;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rdata_q;
  assign rsp_err   = err_q;
  assign halted    = halt_q;

endmodule

// File: doc/debug_access_ctrl.md
Name: debug_access_ctrl

Overview:
- Debug/coprocessor access sequencer that sits directly upstream of the datapath's coprocessor IO port.
- Accepts commands from a host link (UART bridge or JTAG shim) over a valid/ready request channel.
- Halts, resumes or single-steps the core.
- Sequences GPR/CSR reads and writes by driving the datapath's debug address, control and write-data lines, and returns results on a valid/ready response channel.

Parameters:
- N, 64, data width of GPRs/CSRs and of the debug data buses.
- RD_SETTLE, 1, cycles (at least 1) a read access is held before the read data is captured.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host command valid.
- req_ready  out  1  block can accept a command.
- req_cmd  in  3  command code: 0 STATUS, 1 HALT, 2 RESUME, 3 STEP, 4 RD_GPR, 5 WR_GPR, 6 RD_CSR, 7 WR_CSR.
- req_addr  in  12  GPR index in [4:0], or CSR address in [11:0].
- req_data  in  N  write data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  N  read data; {N-1{0}, halted} for STATUS; 0 otherwise.
- rsp_err  out  1  command illegal in the current state.
- halted  out  1  core is held.
- coprocessorIOAddr  out  15  [11:0] CSR address or [4:0] GPR index; [14:12] always 0.
- coprocessorIOControl  out  5  bit [0] write enable, [1] read access, [2] halt hold, [3] CSR select, [4] reserved (always 0). Any nonzero value freezes the PC.
- coprocessorIODataOut  out  N  write data to the GPR/CSR.
- coprocessorIODataIn  in  N  read data from the GPR/CSR.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset has priority over all activity, including mid-operation.
- Reset values:
  - state RUN; halted=0.
  - All coprocessorIO* outputs 0.
  - req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - A reset during an access aborts it: no write is completed, and the core runs on the next cycle.
- States: RUN, HALTED, ACCESS, STEP, RESP.
- Request acceptance:
  - req_ready=1 only in RUN or HALTED; 0 in ACCESS, STEP and RESP.
  - A command is accepted on req_valid && req_ready.
- Response handshake:
  - Every accepted command produces exactly one response, registered in RESP.
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_ready.
  - The response completes on rsp_valid && rsp_ready. The next state is then HALTED if the halt flag is set, else RUN.
  - A new request can be accepted on the cycle after that.
- Halt flag: coprocessorIOControl[2] is set whenever the halt flag is set and the state is not STEP.
- STATUS: legal in any idle state. Goes to RESP with rsp_data[0]=halt flag.
- HALT: sets the halt flag in the cycle after acceptance, then goes to RESP (err=0). Legal and idempotent when already halted.
- RESUME: clears the halt flag, then goes to RESP (err=0). Legal and idempotent in RUN.
- STEP:
  - Legal only when halted. Goes to STEP for exactly one cycle with coprocessorIOControl=0, so exactly one instruction retires.
  - Then re-asserts halt and goes to RESP.
  - STEP issued in RUN goes to RESP with err=1; control lines are untouched.
- Access commands (RD_GPR, WR_GPR, RD_CSR, WR_CSR):
  - Legal only when halted. In RUN they go to RESP with err=1, and no bit other than [2] is ever asserted.
  - In ACCESS, coprocessorIOAddr is {3'b0, req_addr} for CSR, or {10'b0, req_addr[4:0]} for GPR. Bit [3]=1 for CSR.
- Reads:
  - Hold control = halt | read | csr_sel for RD_SETTLE cycles.
  - coprocessorIODataIn is captured into rsp_data on the last of those cycles.
  - Read response appears RD_SETTLE+1 cycles after acceptance.
- Writes:
  - coprocessorIODataOut=req_data.
  - Bit [0] is high for exactly one cycle; then go to RESP.
  - Write response appears 2 cycles after acceptance.
- Outside ACCESS: coprocessorIOAddr, coprocessorIODataOut and control bits [1:0],[3] return to 0.
- GPR index 0: writes are issued normally; the register file discards them. Reads return 0.
- req_addr[11:5] is ignored for GPR commands.

Decomposition:
- Package dbg_pkg holds:
  - cmd_e enum (3-bit).
  - state_e enum.
  - Control bit index localparams: CTL_WE=0, CTL_RE=1, CTL_HALT=2, CTL_CSR=3.
- Single module, no sub-module. The settle counter is a $clog2(RD_SETTLE+1)-bit down-counter inside the module.

Test Plan:
- Reset, then STATUS -> rsp_data=0, rsp_err=0, halted=0, coprocessorIOControl=5'b00000.
- RD_GPR addr=5 while running -> rsp_err=1; coprocessorIOControl never leaves 0. Then HALT -> halted=1, control=5'b00100 one cycle after acceptance.
- Halted; WR_GPR addr=5 data=64'hDEAD_BEEF -> exactly one cycle of control=5'b00101 with addr=15'd5. Then RD_GPR 5 -> rsp_data=64'hDEAD_BEEF, valid 2 cycles after acceptance (RD_SETTLE=1).
- Halted; WR_CSR addr=12'h305 data=64'h8000_0000 -> control=5'b01101, addr=15'h305 for one cycle. RD_CSR 12'h305 -> 64'h8000_0000. Hold rsp_ready=0 for 5 cycles: response stays stable and req_ready=0 throughout.
- Halted; STEP -> exactly one cycle with control=0 (PC advances by 4), then halt re-asserted. STEP while running -> rsp_err=1.
- Reset asserted during a RD_SETTLE=3 read -> next cycle state RUN, all outputs at reset values, no response.
